// File: rtl/ksk_mgr_slot_alloc_pkg.sv
// Shared types and helpers for the KSK slot allocator.
package ksk_mgr_slot_alloc_pkg;

   typedef enum logic [1:0] {
      SLOT_FREE    = 2'd0,
      SLOT_LOADING = 2'd1,
      SLOT_READY   = 2'd2
   } slot_state_e;

   // Sticky error bit positions
   localparam int unsigned ERR_REL_ZERO   = 0;
   localparam int unsigned ERR_FILL_STATE = 1;
   localparam int unsigned ERR_REF_OVF    = 2;
   localparam int unsigned ERR_W          = 3;

   // Index width for a slot count; never below one bit
   function automatic int unsigned slot_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ksk_mgr_slot_rr_picker.sv
// Find-first-set over a mask, starting at a rotating pointer and wrapping.
module ksk_mgr_slot_rr_picker
   import ksk_mgr_slot_alloc_pkg::*;
#(
   parameter int unsigned N = 8,
   localparam int unsigned IDX_W = slot_w(N)
) (
   input  logic [N-1:0]     i_mask,
   input  logic [IDX_W-1:0] i_ptr,
   output logic             o_vld_c,
   output logic [IDX_W-1:0] o_idx_c
);

   // Scan N positions from i_ptr, first set bit wins
   always_comb begin
      int unsigned j;
      o_vld_c = 1'b0;
      o_idx_c = '0;
      j       = 0;
      for (int unsigned k = 0; k < N; k++) begin
         j = 32'(i_ptr) + k;
         if (j >= N) j = j - N;
         if (!o_vld_c && i_mask[IDX_W'(j)]) begin
            o_vld_c = 1'b1;
            o_idx_c = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/ksk_mgr_slot_alloc.sv
// Key-switch-key slot allocator/tracker: allocation, fill tracking,
// consumer lookups with reference counting, release and flush.
// Optional statistics counters when KSK_MGR_SLOT_STATS_EN is defined.
module ksk_mgr_slot_alloc
   import ksk_mgr_slot_alloc_pkg::*;
#(
   parameter int unsigned KSK_SLOT_NB = 8,
   parameter int unsigned LOOP_W      = 8,
   parameter int unsigned REF_W       = 4,
   localparam int unsigned SLOT_W     = slot_w(KSK_SLOT_NB)
) (
   input  logic              clk,
   input  logic              s_rst,
   input  logic              alloc_vld,
   output logic              alloc_rdy,
   input  logic [LOOP_W-1:0] alloc_loop,
   output logic              alloc_ack_vld,
   output logic [SLOT_W-1:0] alloc_ack_slot,
   input  logic              fill_done_vld,
   input  logic [SLOT_W-1:0] fill_done_slot,
   input  logic              lookup_vld,
   input  logic [LOOP_W-1:0] lookup_loop,
   output logic              lookup_ack_vld,
   output logic              lookup_ack_hit,
   output logic [SLOT_W-1:0] lookup_ack_slot,
   input  logic              release_vld,
   input  logic [SLOT_W-1:0] release_slot,
   input  logic              flush_vld,
   output logic [2:0]        error
`ifdef KSK_MGR_SLOT_STATS_EN
   ,
   output logic [31:0]       stat_hit_cnt,
   output logic [31:0]       stat_miss_cnt,
   output logic [31:0]       stat_evict_cnt
`endif
);

   typedef struct packed {
      slot_state_e       state;
      logic [LOOP_W-1:0] loop;
      logic [REF_W-1:0]  refc;
   } slot_info_t;

   localparam logic [REF_W-1:0] REF_MAX = {REF_W{1'b1}};

   slot_info_t          r_slot [KSK_SLOT_NB];
   slot_info_t          w_slot_nxt [KSK_SLOT_NB];
   logic [SLOT_W-1:0]   r_rr_ptr;
   logic [SLOT_W-1:0]   w_rr_ptr_nxt;
   logic                r_alloc_ack_vld;
   logic [SLOT_W-1:0]   r_alloc_ack_slot;
   logic                r_lk_vld;
   logic                r_lk_hit;
   logic [SLOT_W-1:0]   r_lk_slot;
   logic [ERR_W-1:0]    r_error;
   logic [ERR_W-1:0]    w_error_nxt;

   logic [KSK_SLOT_NB-1:0] w_lk_match;
   logic [KSK_SLOT_NB-1:0] w_free_mask;
   logic [KSK_SLOT_NB-1:0] w_recl_mask;
   logic [KSK_SLOT_NB-1:0] w_hit_sel;
   logic [KSK_SLOT_NB-1:0] w_rel_sel;
   logic [KSK_SLOT_NB-1:0] w_fill_sel;
   logic [KSK_SLOT_NB-1:0] w_alloc_sel;
   logic                   w_hit;
   logic [SLOT_W-1:0]      w_hit_idx;
   logic                   w_free_vld;
   logic [SLOT_W-1:0]      w_free_idx;
   logic                   w_recl_vld;
   logic [SLOT_W-1:0]      w_recl_idx;
   logic                   w_alloc_fire;
   logic [SLOT_W-1:0]      w_alloc_idx;
   logic                   w_evict;

   // Per-slot masks: lookup matches, free slots, reclaimable idle slots
   always_comb begin
      w_lk_match  = '0;
      w_free_mask = '0;
      w_recl_mask = '0;
      for (int unsigned i = 0; i < KSK_SLOT_NB; i++) begin
         w_lk_match[i]  = lookup_vld && (r_slot[i].state == SLOT_READY) &&
                          (r_slot[i].loop == lookup_loop);
         w_free_mask[i] = (r_slot[i].state == SLOT_FREE);
         w_recl_mask[i] = (r_slot[i].state == SLOT_READY) &&
                          (r_slot[i].refc == '0) && !w_lk_match[i];
      end
   end

   // Lookup hit: lowest matching slot (a loop is held by at most one slot)
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int unsigned i = 0; i < KSK_SLOT_NB; i++) begin
         if (!w_hit && w_lk_match[i]) begin
            w_hit     = 1'b1;
            w_hit_idx = SLOT_W'(i);
         end
      end
   end

   ksk_mgr_slot_rr_picker #(.N(KSK_SLOT_NB)) u_free_pick (
      .i_mask  (w_free_mask),
      .i_ptr   (r_rr_ptr),
      .o_vld_c (w_free_vld),
      .o_idx_c (w_free_idx)
   );

   ksk_mgr_slot_rr_picker #(.N(KSK_SLOT_NB)) u_recl_pick (
      .i_mask  (w_recl_mask),
      .i_ptr   (r_rr_ptr),
      .o_vld_c (w_recl_vld),
      .o_idx_c (w_recl_idx)
   );

   assign alloc_rdy    = w_free_vld | w_recl_vld;
   assign w_alloc_fire = alloc_vld & alloc_rdy;
   assign w_alloc_idx  = w_free_vld ? w_free_idx : w_recl_idx;
   assign w_evict      = w_alloc_fire & ~w_free_vld;

   // Decode per-slot events from the slot-indexed request ports
   always_comb begin
      w_hit_sel   = '0;
      w_rel_sel   = '0;
      w_fill_sel  = '0;
      w_alloc_sel = '0;
      for (int unsigned i = 0; i < KSK_SLOT_NB; i++) begin
         w_hit_sel[i]   = w_hit && (w_hit_idx == SLOT_W'(i));
         w_rel_sel[i]   = release_vld && (release_slot == SLOT_W'(i));
         w_fill_sel[i]  = fill_done_vld && (fill_done_slot == SLOT_W'(i));
         w_alloc_sel[i] = w_alloc_fire && (w_alloc_idx == SLOT_W'(i));
      end
   end

   // Next slot table: ref count, then fill, then alloc/dedup, then flush
   always_comb begin
      w_error_nxt = r_error;
      for (int unsigned i = 0; i < KSK_SLOT_NB; i++) begin
         w_slot_nxt[i] = r_slot[i];
         // Simultaneous take and give on one slot cancel out
         if (w_hit_sel[i] && !w_rel_sel[i]) begin
            if (r_slot[i].refc == REF_MAX) w_error_nxt[ERR_REF_OVF] = 1'b1;
            else w_slot_nxt[i].refc = r_slot[i].refc + REF_W'(1);
         end else if (w_rel_sel[i] && !w_hit_sel[i]) begin
            if (r_slot[i].refc == '0) w_error_nxt[ERR_REL_ZERO] = 1'b1;
            else w_slot_nxt[i].refc = r_slot[i].refc - REF_W'(1);
         end
         if (w_fill_sel[i]) begin
            if (r_slot[i].state == SLOT_LOADING) w_slot_nxt[i].state = SLOT_READY;
            else w_error_nxt[ERR_FILL_STATE] = 1'b1;
         end
         if (w_alloc_sel[i]) begin
            w_slot_nxt[i].state = SLOT_LOADING;
            w_slot_nxt[i].loop  = alloc_loop;
            w_slot_nxt[i].refc  = '0;
         end else if (w_alloc_fire && (r_slot[i].state == SLOT_READY) &&
                      (r_slot[i].loop == alloc_loop)) begin
            w_slot_nxt[i].state = SLOT_FREE;
         end else if (flush_vld && (r_slot[i].state == SLOT_READY) &&
                      (r_slot[i].refc == '0) && !w_hit_sel[i]) begin
            // A slot handed to a consumer this cycle is already in use
            w_slot_nxt[i].state = SLOT_FREE;
         end
      end
   end

   // Round-robin pointer advances past the granted slot
   always_comb begin
      w_rr_ptr_nxt = r_rr_ptr;
      if (w_alloc_fire) begin
         if (32'(w_alloc_idx) == KSK_SLOT_NB - 1) w_rr_ptr_nxt = '0;
         else w_rr_ptr_nxt = w_alloc_idx + SLOT_W'(1);
      end
   end

   // Slot table, pointer, acknowledges and sticky errors
   always_ff @(posedge clk) begin
      if (s_rst) begin
         for (int unsigned i = 0; i < KSK_SLOT_NB; i++) begin
            r_slot[i].state <= SLOT_FREE;
            r_slot[i].loop  <= '0;
            r_slot[i].refc  <= '0;
         end
         r_rr_ptr         <= '0;
         r_alloc_ack_vld  <= 1'b0;
         r_alloc_ack_slot <= '0;
         r_lk_vld         <= 1'b0;
         r_lk_hit         <= 1'b0;
         r_lk_slot        <= '0;
         r_error          <= '0;
      end else begin
         for (int unsigned i = 0; i < KSK_SLOT_NB; i++) begin
            r_slot[i] <= w_slot_nxt[i];
         end
         r_rr_ptr         <= w_rr_ptr_nxt;
         r_alloc_ack_vld  <= w_alloc_fire;
         r_alloc_ack_slot <= w_alloc_fire ? w_alloc_idx : r_alloc_ack_slot;
         r_lk_vld         <= lookup_vld;
         r_lk_hit         <= w_hit;
         r_lk_slot        <= w_hit_idx;
         r_error          <= w_error_nxt;
      end
   end

   assign alloc_ack_vld   = r_alloc_ack_vld;
   assign alloc_ack_slot  = r_alloc_ack_slot;
   assign lookup_ack_vld  = r_lk_vld;
   assign lookup_ack_hit  = r_lk_hit;
   assign lookup_ack_slot = r_lk_slot;
   assign error           = r_error;

`ifdef KSK_MGR_SLOT_STATS_EN
   logic [31:0] r_stat_hit;
   logic [31:0] r_stat_miss;
   logic [31:0] r_stat_evict;

   // Saturating hit/miss/eviction counters
   always_ff @(posedge clk) begin
      if (s_rst) begin
         r_stat_hit   <= '0;
         r_stat_miss  <= '0;
         r_stat_evict <= '0;
      end else begin
         if (lookup_vld && w_hit && (r_stat_hit != '1))
            r_stat_hit <= r_stat_hit + 32'd1;
         if (lookup_vld && !w_hit && (r_stat_miss != '1))
            r_stat_miss <= r_stat_miss + 32'd1;
         if (w_evict && (r_stat_evict != '1))
            r_stat_evict <= r_stat_evict + 32'd1;
      end
   end

   assign stat_hit_cnt   = r_stat_hit;
   assign stat_miss_cnt  = r_stat_miss;
   assign stat_evict_cnt = r_stat_evict;
`else
   logic w_evict_unused;
   assign w_evict_unused = w_evict;
`endif

endmodule

// File: tb/tb_ksk_mgr_slot_alloc.sv
// Directed bench for ksk_mgr_slot_alloc with default parameters.
module tb_ksk_mgr_slot_alloc;

   localparam int unsigned LW = 8;
   localparam int unsigned SW = 3;

   logic          clk = 1'b0;
   logic          s_rst;
   logic          alloc_vld;
   logic          alloc_rdy;
   logic [LW-1:0] alloc_loop;
   logic          alloc_ack_vld;
   logic [SW-1:0] alloc_ack_slot;
   logic          fill_done_vld;
   logic [SW-1:0] fill_done_slot;
   logic          lookup_vld;
   logic [LW-1:0] lookup_loop;
   logic          lookup_ack_vld;
   logic          lookup_ack_hit;
   logic [SW-1:0] lookup_ack_slot;
   logic          release_vld;
   logic [SW-1:0] release_slot;
   logic          flush_vld;
   logic [2:0]    error;
`ifdef KSK_MGR_SLOT_STATS_EN
   logic [31:0]   stat_hit_cnt;
   logic [31:0]   stat_miss_cnt;
   logic [31:0]   stat_evict_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ksk_mgr_slot_alloc dut (
      .clk             (clk),
      .s_rst           (s_rst),
      .alloc_vld       (alloc_vld),
      .alloc_rdy       (alloc_rdy),
      .alloc_loop      (alloc_loop),
      .alloc_ack_vld   (alloc_ack_vld),
      .alloc_ack_slot  (alloc_ack_slot),
      .fill_done_vld   (fill_done_vld),
      .fill_done_slot  (fill_done_slot),
      .lookup_vld      (lookup_vld),
      .lookup_loop     (lookup_loop),
      .lookup_ack_vld  (lookup_ack_vld),
      .lookup_ack_hit  (lookup_ack_hit),
      .lookup_ack_slot (lookup_ack_slot),
      .release_vld     (release_vld),
      .release_slot    (release_slot),
      .flush_vld       (flush_vld),
      .error           (error)
`ifdef KSK_MGR_SLOT_STATS_EN
      ,
      .stat_hit_cnt    (stat_hit_cnt),
      .stat_miss_cnt   (stat_miss_cnt),
      .stat_evict_cnt  (stat_evict_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      alloc_vld     = 1'b0;
      fill_done_vld = 1'b0;
      lookup_vld    = 1'b0;
      release_vld   = 1'b0;
      flush_vld     = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rdy(input string tag, input int exp);
      #1;
      check(tag, 32'(alloc_rdy), 32'(exp));
   endtask

   task automatic do_alloc(input string tag, input logic [LW-1:0] loop, input int exp_slot);
      alloc_vld  = 1'b1;
      alloc_loop = loop;
      step();
      clr();
      check({tag, "_vld"}, 32'(alloc_ack_vld), 1);
      check({tag, "_slot"}, 32'(alloc_ack_slot), 32'(exp_slot));
   endtask

   task automatic do_lookup(input string tag, input logic [LW-1:0] loop,
                            input int exp_hit, input int exp_slot);
      lookup_vld  = 1'b1;
      lookup_loop = loop;
      step();
      clr();
      check({tag, "_vld"}, 32'(lookup_ack_vld), 1);
      check({tag, "_hit"}, 32'(lookup_ack_hit), 32'(exp_hit));
      check({tag, "_slot"}, 32'(lookup_ack_slot), 32'(exp_slot));
   endtask

   task automatic do_fill(input logic [SW-1:0] slot);
      fill_done_vld  = 1'b1;
      fill_done_slot = slot;
      step();
      clr();
   endtask

   task automatic do_release(input logic [SW-1:0] slot);
      release_vld  = 1'b1;
      release_slot = slot;
      step();
      clr();
   endtask

   initial begin
      clr();
      alloc_loop     = '0;
      fill_done_slot = '0;
      lookup_loop    = '0;
      release_slot   = '0;
      s_rst          = 1'b1;
      step();
      step();
      s_rst = 1'b0;

      // Reset state
      check("rst_alloc_ack_vld", 32'(alloc_ack_vld), 0);
      check("rst_alloc_ack_slot", 32'(alloc_ack_slot), 0);
      check("rst_lookup_ack_vld", 32'(lookup_ack_vld), 0);
      check("rst_lookup_ack_hit", 32'(lookup_ack_hit), 0);
      check("rst_lookup_ack_slot", 32'(lookup_ack_slot), 0);
      check("rst_error", 32'(error), 0);
      check_rdy("rst_rdy", 1);

      // Fill every slot in round-robin order
      for (int k = 0; k < 8; k++) do_alloc($sformatf("alloc%0d", k), LW'(k), k);
      check_rdy("rdy_all_loading", 0);
      step();
      check("ack_pulse_drop", 32'(alloc_ack_vld), 0);

      // Load slot 3 then look it up; held ref keeps it out of the candidates
      do_fill(3'd3);
      do_lookup("lk3", 8'd3, 1, 3);
      check_rdy("rdy_slot3_held", 0);
      do_lookup("lk9", 8'd9, 0, 0);
      step();
      check("lk_pulse_drop", 32'(lookup_ack_vld), 0);
      do_release(3'd3);
      check("err_after_rel3", 32'(error), 0);
      check_rdy("rdy_slot3_idle", 1);

      // All READY with ref 0, pointer at 0
      for (int k = 0; k < 8; k++) if (k != 3) do_fill(SW'(k));
      check("err_after_fills", 32'(error), 0);

      // Lookup of slot 0 shields it from the concurrent allocation
      lookup_vld  = 1'b1;
      lookup_loop = 8'd0;
      alloc_vld   = 1'b1;
      alloc_loop  = 8'd20;
      step();
      clr();
      check("sim_lk_hit", 32'(lookup_ack_hit), 1);
      check("sim_lk_slot", 32'(lookup_ack_slot), 0);
      check("sim_alloc_vld", 32'(alloc_ack_vld), 1);
      check("sim_alloc_slot", 32'(alloc_ack_slot), 1);

      // Lookup and release on slot 0 together: ref stays at 1
      lookup_vld   = 1'b1;
      lookup_loop  = 8'd0;
      release_vld  = 1'b1;
      release_slot = 3'd0;
      step();
      clr();
      check("lkrel_hit", 32'(lookup_ack_hit), 1);
      check("lkrel_err", 32'(error), 0);

      // Saturate slot 6 ref counter (15), 16th lookup overflows but hits
      for (int k = 0; k < 15; k++) do_lookup($sformatf("ovf%0d", k), 8'd6, 1, 6);
      check("ovf_no_err_yet", 32'(error), 0);
      do_lookup("ovf15", 8'd6, 1, 6);
      check("ovf_err", 32'(error), 4);

      // Slot 0 still has one ref: first release is legal
      do_release(3'd0);
      check("rel0_ok", 32'(error), 4);
      do_release(3'd5);
      check("rel5_zero", 32'(error), 5);
      step();
      check("err_sticky", 32'(error), 5);
      do_fill(3'd4);
      check("fill_ready_err", 32'(error), 7);

      // Reclaim from pointer 2 (slot 1 LOADING, slot 6 referenced)
      do_alloc("recl2", 8'd21, 2);
      // Reclaim slot 3 for loop 5; the READY copy in slot 5 is dropped
      do_alloc("dedup", 8'd5, 3);
      do_lookup("lk5_gone", 8'd5, 0, 0);
      // Free slot 5 preferred over idle READY slots
      do_alloc("free_pref", 8'd30, 5);
      do_lookup("lk_loading", 8'd20, 0, 0);

      // Flush: idle READY slots 0, 4, 7 freed; referenced slot 6 kept
      flush_vld = 1'b1;
      step();
      clr();
      do_lookup("fl_lk0", 8'd0, 0, 0);
      do_lookup("fl_lk6", 8'd6, 1, 6);
      do_lookup("fl_lk7", 8'd7, 0, 0);
      do_alloc("fl_alloc7", 8'd40, 7);
      do_alloc("fl_alloc0", 8'd41, 0);

      // Reset in the middle of an allocation
      alloc_vld  = 1'b1;
      alloc_loop = 8'd50;
      s_rst      = 1'b1;
      step();
      s_rst = 1'b0;
      clr();
      check("mid_rst_ack", 32'(alloc_ack_vld), 0);
      check("mid_rst_err", 32'(error), 0);
      check("mid_rst_lk", 32'(lookup_ack_vld), 0);
      check_rdy("mid_rst_rdy", 1);
      do_lookup("post_rst_lk6", 8'd6, 0, 0);
      do_alloc("post_rst_alloc", 8'd1, 0);
      do_fill(3'd0);
      check("post_rst_fill_err", 32'(error), 0);
      do_lookup("post_rst_lk1", 8'd1, 1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
